// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the multi-channel button debouncer.
package debounce_pkg;

   localparam int DEF_NCH       = 4;
   localparam int DEF_DEPTH     = 3;
   localparam int DEF_HB_BITS   = 20;
   localparam int DEF_REP_DELAY = 32;
   localparam int DEF_REP_RATE  = 8;

   // The repeat counter only ever has to reach REP_DELAY, so it needs just
   // enough bits to hold that value.
   function automatic int rep_cnt_width(input int rep_delay);
      int w;
      w = $clog2(rep_delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: sample window, hysteresis level, press/release pulses.
// Optional auto-repeat of the press pulse when DEBOUNCE_REPEAT_EN is defined.
// 'rel' is the release pulse ('release' is a reserved word in SystemVerilog).
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int REP_DELAY = DEF_REP_DELAY,
   parameter int REP_RATE  = DEF_REP_RATE
) (
   input  logic vgaclk,
   input  logic reset,
   input  logic tick,
   input  logic sample,
   output logic level,
   output logic press,
   output logic rel
);

   if (DEPTH < 2 || DEPTH > 8 || REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_param
      $error("debounce_chan: parameter out of range");
   end

   logic [DEPTH-1:0] win_q, win_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             rise, fall;
   logic             rep_fire;

   // Shift the window on a tick; level moves only on a unanimous window.
   always_comb begin
      win_d   = win_q;
      level_d = level_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (tick) begin
         win_d = {win_q[DEPTH-2:0], sample};
         if (!level_q && (&win_d)) begin
            level_d = 1'b1;
            rise    = 1'b1;
         end else if (level_q && !(|win_d)) begin
            level_d = 1'b0;
            fall    = 1'b1;
         end
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int RW = rep_cnt_width(REP_DELAY);
   localparam logic [RW-1:0] REP_LAST = RW'(REP_DELAY - 1);
   // After a repeat the counter drops back by REP_RATE so the next repeat
   // lands REP_RATE ticks later; a rate longer than the delay is capped.
   localparam logic [RW-1:0] REP_RELOAD =
      (REP_RATE >= REP_DELAY) ? '0 : RW'(REP_DELAY - REP_RATE);

   logic [RW-1:0] rep_q, rep_d;

   // Count ticks while held; the counter never exceeds REP_DELAY-1, so it cannot wrap.
   always_comb begin
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (rise || fall) begin
         rep_d = '0;
      end else if (tick && level_q) begin
         if (rep_q == REP_LAST) begin
            rep_fire = 1'b1;
            rep_d    = REP_RELOAD;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   // Repeat counter register.
   always_ff @(posedge vgaclk) begin
      if (reset) rep_q <= '0;
      else       rep_q <= rep_d;
   end
`else
   // No auto-repeat in this build.
   always_comb begin
      rep_fire = 1'b0;
   end
`endif

   // Pulse decode; a fall on the same tick suppresses any repeat.
   always_comb begin
      press_d = rise | rep_fire;
      rel_d   = fall;
   end

   // Channel state registers.
   always_ff @(posedge vgaclk) begin
      if (reset) begin
         win_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         win_q   <= win_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: synchronisers, shared sample tick,
// optional mutual exclusion, and NCH debounce_chan instances.
// Build option: DEBOUNCE_REPEAT_EN enables press auto-repeat.
// 'rel' carries the per-channel release pulse ('release' is a reserved word).
module multi_debounce
   import debounce_pkg::*;
#(
   parameter int NCH       = DEF_NCH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int HB_BITS   = DEF_HB_BITS,
   parameter int EXCL      = 1,
   parameter int REP_DELAY = DEF_REP_DELAY,
   parameter int REP_RATE  = DEF_REP_RATE
) (
   input  logic           vgaclk,
   input  logic           reset,
   input  logic [NCH-1:0] btn,
   output logic [NCH-1:0] level,
   output logic [NCH-1:0] press,
   output logic [NCH-1:0] rel,
   output logic           tick
);

   if (NCH < 1 || NCH > 8 || HB_BITS < 1) begin : g_bad_param
      $error("multi_debounce: parameter out of range");
   end

   logic [NCH-1:0]     sync1_q, sync1_d;
   logic [NCH-1:0]     sync2_q, sync2_d;
   logic [HB_BITS-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]     sample;

   // Two-stage synchroniser and free-running tick counter.
   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      cnt_d   = cnt_q + 1'b1;
   end

   // Synchroniser and tick counter registers.
   always_ff @(posedge vgaclk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tick = &cnt_q;

   // Exclusion: a channel samples high only if it is the sole button held.
   always_comb begin : excl_gate
      logic [NCH-1:0] others;
      others = '0;
      sample = sync2_q;
      if (EXCL != 0) begin
         for (int i = 0; i < NCH; i++) begin
            others    = sync2_q;
            others[i] = 1'b0;
            sample[i] = sync2_q[i] & ~(|others);
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      debounce_chan #(
         .DEPTH     (DEPTH),
         .REP_DELAY (REP_DELAY),
         .REP_RATE  (REP_RATE)
      ) u_chan (
         .vgaclk (vgaclk),
         .reset  (reset),
         .tick   (tick),
         .sample (sample[g]),
         .level  (level[g]),
         .press  (press[g]),
         .rel    (rel[g])
      );
   end

endmodule
